// File: rtl/io_rgb_pwm.sv
// rtl/io_rgb_pwm.sv - multi-channel RGB LED PWM controller on the dma_io bus
//
// Per-colour PWM brightness with a shared prescaler and PWM counter, duty
// shadow registers loaded on PWM wrap, and optional per-channel blinking
// (built only when IO_RGB_PWM_BLINK_EN is defined).
//
// Ports:
//   clk             system clock
//   rst             asynchronous active-high reset
//   dma_io_we       write strobe
//   dma_io_wadr     write word address [15:2]
//   dma_io_wdata    write data
//   dma_io_radr     read word address [15:2]
//   dma_io_radr_en  read strobe
//   dma_io_rdata_in read data from upstream chain
//   dma_io_rdata    read data to downstream chain
//   rgb_led         channel c: bit 3c blue, 3c+1 green, 3c+2 red
module io_rgb_pwm #(
  parameter int          NCH      = 4,
  parameter int          PWM_W    = 8,
  parameter logic [13:0] BASE_ADR = 14'h3E00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dma_io_we,
  input  logic [13:0]      dma_io_wadr,
  input  logic [31:0]      dma_io_wdata,
  input  logic [13:0]      dma_io_radr,
  input  logic             dma_io_radr_en,
  input  logic [31:0]      dma_io_rdata_in,
  output logic [31:0]      dma_io_rdata,
  output logic [3*NCH-1:0] rgb_led
);

  localparam logic [14:0]      PRESC_OFF = 15'(2 * NCH);
  localparam logic [PWM_W-1:0] PWM_MAX   = '1;

  // Offset is computed one bit wider so addresses below BASE_ADR show up
  // as a set MSB rather than aliasing onto the map.
  function automatic logic [14:0] adr_off(input logic [13:0] a);
    return {1'b0, a} - {1'b0, BASE_ADR};
  endfunction

  function automatic logic adr_hit(input logic [13:0] a);
    logic [14:0] o;
    o = adr_off(a);
    return !o[14] && (o <= PRESC_OFF);
  endfunction

  logic [NCH-1:0][3*PWM_W-1:0] duty_sh_q, duty_sh_d;
  logic [NCH-1:0][3*PWM_W-1:0] duty_act_q, duty_act_d;
  logic [NCH-1:0]              enable_q, enable_d;
  logic [15:0]                 presc_q, presc_d;
  logic [15:0]                 presc_cnt_q, presc_cnt_d;
  logic [PWM_W-1:0]            pwm_cnt_q, pwm_cnt_d;
  logic [3*NCH-1:0]            rgb_led_q, rgb_led_d;
  logic                        rd_hit_q, rd_hit_d;
  logic [31:0]                 rd_data_q, rd_data_d;

  logic        tick;
  logic        wrap;
  logic [14:0] woff;
  logic [14:0] roff;
  logic [NCH-1:0] phase;

  // Not every write-data bit maps onto a register field.
  logic unused_wdata;
  assign unused_wdata = ^dma_io_wdata;

`ifdef IO_RGB_PWM_BLINK_EN
  logic [NCH-1:0]      blink_en_q, blink_en_d;
  logic [NCH-1:0][7:0] blink_per_q, blink_per_d;
  logic [NCH-1:0][7:0] blink_cnt_q, blink_cnt_d;
  logic [NCH-1:0]      phase_q, phase_d;

  assign phase = phase_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_en_q  <= '0;
      blink_per_q <= '0;
      blink_cnt_q <= '0;
      phase_q     <= '1;
    end else begin
      blink_en_q  <= blink_en_d;
      blink_per_q <= blink_per_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  always_comb begin
    blink_en_d  = blink_en_q;
    blink_per_d = blink_per_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    for (int c = 0; c < NCH; c++) begin
      if (!blink_en_q[c]) begin
        phase_d[c]     = 1'b1;
        blink_cnt_d[c] = '0;
      end else if (wrap) begin
        if (blink_cnt_q[c] == blink_per_q[c]) begin
          phase_d[c]     = ~phase_q[c];
          blink_cnt_d[c] = '0;
        end else begin
          blink_cnt_d[c] = blink_cnt_q[c] + 8'd1;
        end
      end
      if (dma_io_we && adr_hit(dma_io_wadr) && (woff == 15'(2 * c + 1))) begin
        blink_en_d[c]  = dma_io_wdata[1];
        blink_per_d[c] = dma_io_wdata[15:8];
      end
    end
  end
`else
  assign phase = '1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_sh_q   <= '0;
      duty_act_q  <= '0;
      enable_q    <= '0;
      presc_q     <= '0;
      presc_cnt_q <= '0;
      pwm_cnt_q   <= '0;
      rgb_led_q   <= '0;
      rd_hit_q    <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      duty_sh_q   <= duty_sh_d;
      duty_act_q  <= duty_act_d;
      enable_q    <= enable_d;
      presc_q     <= presc_d;
      presc_cnt_q <= presc_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      rgb_led_q   <= rgb_led_d;
      rd_hit_q    <= rd_hit_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Counters and register writes.
  always_comb begin
    woff        = adr_off(dma_io_wadr);
    tick        = (presc_cnt_q == presc_q);
    wrap        = tick && (pwm_cnt_q == PWM_MAX);
    presc_cnt_d = tick ? '0 : presc_cnt_q + 16'd1;
    pwm_cnt_d   = tick ? pwm_cnt_q + PWM_W'(1) : pwm_cnt_q;
    // Active duty only changes at a period boundary so no period is cut.
    duty_act_d  = wrap ? duty_sh_q : duty_act_q;
    duty_sh_d   = duty_sh_q;
    enable_d    = enable_q;
    presc_d     = presc_q;
    if (dma_io_we && adr_hit(dma_io_wadr)) begin
      if (woff == PRESC_OFF) begin
        presc_d     = dma_io_wdata[15:0];
        presc_cnt_d = '0;
      end
      for (int c = 0; c < NCH; c++) begin
        if (woff == 15'(2 * c))     duty_sh_d[c] = dma_io_wdata[3*PWM_W-1:0];
        if (woff == 15'(2 * c + 1)) enable_d[c]  = dma_io_wdata[0];
      end
    end
  end

  // PWM compare, registered for a glitch-free output.
  always_comb begin
    rgb_led_d = '0;
    for (int c = 0; c < NCH; c++) begin
      for (int k = 0; k < 3; k++) begin
        rgb_led_d[3*c+k] = enable_q[c] && phase[c] &&
                           (pwm_cnt_q < duty_act_q[c][k*PWM_W +: PWM_W]);
      end
    end
  end

  // Read path: captures pre-write register contents.
  always_comb begin
    roff      = adr_off(dma_io_radr);
    rd_hit_d  = dma_io_radr_en && adr_hit(dma_io_radr);
    rd_data_d = '0;
    if (rd_hit_d) begin
      if (roff == PRESC_OFF) rd_data_d = {16'd0, presc_q};
      for (int c = 0; c < NCH; c++) begin
        if (roff == 15'(2 * c)) rd_data_d = 32'(duty_sh_q[c]);
`ifdef IO_RGB_PWM_BLINK_EN
        if (roff == 15'(2 * c + 1))
          rd_data_d = {16'd0, blink_per_q[c], 6'd0, blink_en_q[c], enable_q[c]};
`else
        if (roff == 15'(2 * c + 1)) rd_data_d = {31'd0, enable_q[c]};
`endif
      end
    end
  end

  assign dma_io_rdata = rd_hit_q ? rd_data_q : dma_io_rdata_in;
  assign rgb_led      = rgb_led_q;

endmodule

// File: doc/io_rgb_pwm.md
# io_rgb_pwm

Parametrised multi-channel RGB LED controller on the CPU's `dma_io` peripheral bus. It is the next generation of the fixed on/off LED port: per-colour PWM brightness, a programmable prescaler, glitch-free duty updates and optional per-channel blinking. It sits in the `dma_io` read-data daisy chain alongside the UART output port.

## Interface
- `NCH`, 4, number of RGB channels (1..16)
- `PWM_W`, 8, PWM resolution in bits (1..10)
- `BASE_ADR`, 14'h3E00, word address (`dma_io` [15:2]) of channel 0 duty register

- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high
- `dma_io_we`  in  1  write strobe
- `dma_io_wadr`  in  14  write word address [15:2]
- `dma_io_wdata`  in  32  write data
- `dma_io_radr`  in  14  read word address [15:2]
- `dma_io_radr_en`  in  1  read strobe
- `dma_io_rdata_in`  in  32  read data from upstream chain
- `dma_io_rdata`  out  32  read data to downstream chain
- `rgb_led`  out  3*NCH  channel c: bit 3c blue, 3c+1 green, 3c+2 red

## Operation
- Register map (word offsets from `BASE_ADR`), all reset to 0:
  - 2c+0 DUTY[c]: [PWM_W-1:0] blue, [2PWM_W-1:PWM_W] green, [3PWM_W-1:2PWM_W] red; upper bits read 0
  - 2c+1 CTRL[c]: bit0 enable, bit1 blink_en, [15:8] blink_period
  - 2NCH PRESC: [15:0] prescaler divide value
- Addresses outside the map: writes ignored, reads pass through.
- Prescaler: `presc_cnt` counts 0..PRESC; `tick` asserted on the cycle `presc_cnt==PRESC`, then `presc_cnt` returns to 0. PRESC=0 means a tick every cycle. A PRESC write clears `presc_cnt`.
- PWM counter `pwm_cnt` (PWM_W bits) increments on each tick and wraps from 2^PWM_W-1 to 0 (`wrap` = tick while at max).
- Duty shadowing: DUTY writes update the shadow (readback value); the active duty is loaded from the shadow only on `wrap`. Period never truncated or glitched.
- Colour output = enable & phase & (`pwm_cnt` < active duty). Duty 0 = always off; max duty = on 2^PWM_W-1 of 2^PWM_W counts.
- Blink (see Configuration): per-channel `blink_cnt` (8 bits) advances on `wrap`; on `wrap` with `blink_cnt==blink_period`, `phase` toggles and `blink_cnt` clears. blink_en=0 forces phase=1 and blink_cnt=0.
- Enable clear: outputs low from the next cycle; duty and counters keep running.
- Read: `dma_io_rdata` = registered hit ? registered register value : `dma_io_rdata_in` (combinational pass-through).

## Timing
- Reset: `rgb_led`=0, `dma_io_rdata` = `dma_io_rdata_in` (hit flag 0), all counters 0, phase=1.
- Write: register updates on the edge sampling `dma_io_we`; CTRL/PRESC effective next cycle; DUTY effective at the next `wrap`.
- Read latency 1 cycle: data for the address sampled with `dma_io_radr_en` appears on `dma_io_rdata` the following cycle, held one cycle only.
- Read and write to the same address in one cycle: read returns the pre-write value.
- `rgb_led` registered: reflects `pwm_cnt` compare with 1 cycle latency.
- PWM period = 2^PWM_W × (PRESC+1) cycles; blink half-period = (blink_period+1) PWM periods.
- Reset asserted mid-period: everything returns to reset values asynchronously; no partial state retained.

## Configuration
- `IO_RGB_PWM_BLINK_EN` defined: blink logic built as above.
- Undefined: no blink counters; phase constant 1; CTRL bit1 and [15:8] not stored, read as 0, writes ignored.

## Test plan
- Reset, read PRESC and all CTRL/DUTY -> 0 after 1 cycle; `rgb_led`=0; unmapped read returns `dma_io_rdata_in` value 32'hDEADBEEF.
- NCH=4, PWM_W=8, PRESC=0, CTRL[1]=1, DUTY[1]=24'h400000 -> red of channel 1 high exactly 64 of every 256 cycles, other bits 0.
- Change DUTY[0] mid-period from 24'h000080 to 24'h000010 -> current period keeps 128-cycle high time, next period 16.
- PRESC=3, DUTY[2] blue=8'hFF, enable -> period 1024 cycles, high 1020; PRESC write mid-count restarts prescaler at 0.
- With `IO_RGB_PWM_BLINK_EN`, PRESC=0, CTRL[0]=32'h0203 -> channel 0 output gated off for 3 PWM periods, on for 3, repeating; without macro CTRL reads 32'h00000001.
- Same-cycle write 0x55 and read of DUTY[3] -> read returns old value; next read returns 0x55; reset asserted mid-blink -> outputs 0 immediately.
